// File: rtl/cpu_issue.sv
// Single-issue instruction sequencer: decodes one 16-bit instruction at a time, hands
// operands to an external ALU, waits for completion with a timeout, and writes back to an 8x16 register file.
module cpu_issue #(
    parameter int TIMEOUT = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic        instr_ready,
    output logic [2:0]  alu_op_code,
    output logic [15:0] alu_src1,
    output logic [15:0] alu_src2,
    input  logic [15:0] alu_result,
    input  logic        alu_done,
    output logic        busy,
    output logic        err_illegal,
    output logic        err_timeout,
    output logic [15:0] retire_count,
    input  logic [2:0]  dbg_addr,
    output logic [15:0] dbg_data
);

    typedef enum logic [2:0] {IDLE, DECODE, ISSUE, WAIT, WB} state_e;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_ADD  = 3'b001,
        OP_ADDI = 3'b010,
        OP_SUB  = 3'b011,
        OP_SUBI = 3'b100,
        OP_MUL  = 3'b101,
        OP_LDI  = 3'b110,
        OP_ILL  = 3'b111
    } opcode_e;

    localparam logic [2:0] CNT_LAST = 3'(TIMEOUT - 1);

    state_e      state, next_state;
    logic [15:0] ir;
    logic [15:0] result;
    logic [2:0]  wait_cnt;
    logic [15:0] regs [8];

    opcode_e     opcode;
    logic [2:0]  rd, rs1, rs2;
    logic [6:0]  imm7;

    assign opcode = opcode_e'(ir[15:13]);
    assign rd     = ir[12:10];
    assign rs1    = ir[9:7];
    assign rs2    = ir[6:4];
    assign imm7   = ir[6:0];

    assign dbg_data = (dbg_addr == 3'd0) ? 16'h0000 : regs[dbg_addr];

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        next_state  = state;
        instr_ready = (state == IDLE);
        busy        = (state != IDLE);
        alu_op_code = (state == ISSUE) ? ir[15:13] : 3'b000;
        case (state)
            IDLE:   if (instr_valid) next_state = DECODE;
            DECODE: begin
                case (opcode)
                    OP_NOP, OP_LDI: next_state = WB;
                    OP_ILL:         next_state = IDLE;
                    default:        next_state = ISSUE;
                endcase
            end
            ISSUE:  next_state = WAIT;
            WAIT: begin
                if (alu_done)                   next_state = WB;
                else if (wait_cnt == CNT_LAST)  next_state = IDLE;
            end
            WB:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ir           <= '0;
            result       <= '0;
            wait_cnt     <= '0;
            alu_src1     <= '0;
            alu_src2     <= '0;
            err_illegal  <= 1'b0;
            err_timeout  <= 1'b0;
            retire_count <= '0;
            // NOTE: the register file is architecturally cleared on reset, so it is built from flops rather than a RAM.
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else begin
            case (state)
                IDLE: if (instr_valid) ir <= instr;
                DECODE: begin
                    case (opcode)
                        OP_ADD, OP_SUB, OP_MUL: begin
                            alu_src1 <= regs[rs1];
                            alu_src2 <= regs[rs2];
                        end
                        OP_ADDI, OP_SUBI: begin
                            alu_src1 <= regs[rs1];
                            alu_src2 <= {9'b0, imm7};
                        end
                        OP_ILL:  err_illegal <= 1'b1;
                        default: ;
                    endcase
                end
                ISSUE: wait_cnt <= '0;
                WAIT: begin
                    if (alu_done)                  result      <= alu_result;
                    else if (wait_cnt == CNT_LAST) err_timeout <= 1'b1;
                    else                           wait_cnt    <= wait_cnt + 3'd1;
                end
                WB: begin
                    // r0 is hardwired to zero, so its write is simply dropped.
                    if (opcode == OP_LDI && rd != 3'd0)
                        regs[rd] <= {6'b0, ir[9:0]};
                    else if (opcode != OP_NOP && rd != 3'd0)
                        regs[rd] <= result;
                    retire_count <= retire_count + 16'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_issue.sv
// Self-checking bench for cpu_issue: directed scenarios followed by random instructions,
// compared cycle by cycle against an architectural model of the register file and counters.
module tb_cpu_issue;

    localparam int TIMEOUT = 7;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic [2:0]  alu_op_code;
    logic [15:0] alu_src1, alu_src2;
    logic [15:0] alu_result;
    logic        alu_done;
    logic        busy;
    logic        err_illegal, err_timeout;
    logic [15:0] retire_count;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    cpu_issue #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .alu_op_code(alu_op_code),
        .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_result(alu_result),
        .alu_done(alu_done), .busy(busy), .err_illegal(err_illegal),
        .err_timeout(err_timeout), .retire_count(retire_count),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Architectural model state.
    logic [15:0] m_regs [8];
    logic [15:0] m_retire;
    logic        m_ill, m_tmo;
    logic [15:0] m_src1, m_src2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
        m_retire = 16'h0;
        m_ill    = 1'b0;
        m_tmo    = 1'b0;
        m_src1   = 16'h0;
        m_src2   = 16'h0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ready"},  instr_ready, 1'b1);
        check({tag, "_busy"},   busy, 1'b0);
        check({tag, "_op"},     alu_op_code, 3'b000);
        check({tag, "_ill"},    err_illegal, m_ill);
        check({tag, "_tmo"},    err_timeout, m_tmo);
        check({tag, "_retire"}, retire_count, m_retire);
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            check($sformatf("%s_r%0d", tag, i), dbg_data, m_regs[i]);
        end
    endtask

    function automatic logic [15:0] alu_model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p;
        p = 32'(a) * 32'(b);
        case (op)
            3'b001, 3'b010: return a + b;
            3'b011, 3'b100: return a - b;
            default:        return p[15:0];
        endcase
    endfunction

    // Drive noise on inputs that the block must ignore in the current cycle.
    task automatic noise();
        instr_valid = 1'($urandom);
        instr       = 16'($urandom);
        alu_done    = 1'($urandom);
        alu_result  = 16'($urandom);
    endtask

    // Runs one instruction starting from an IDLE negedge. delay = WAIT cycles before alu_done
    // (>= TIMEOUT means never); rst_k >= 0 applies reset in that WAIT cycle instead.
    task automatic run(input logic [15:0] ins, input int delay, input int rst_k);
        logic [2:0]  op;
        logic [2:0]  rd, rs1, rs2;
        logic [15:0] res;
        op  = ins[15:13];
        rd  = ins[12:10];
        rs1 = ins[9:7];
        rs2 = ins[6:4];

        check_idle("idle");
        instr_valid = 1'b1;
        instr       = ins;
        alu_done    = 1'b0;
        step();
        check("dec_busy",  busy, 1'b1);
        check("dec_ready", instr_ready, 1'b0);
        check("dec_op",    alu_op_code, 3'b000);
        noise();
        step();

        if (op == 3'b111) begin
            m_ill = 1'b1;
            check("ill_ready", instr_ready, 1'b1);
            check("ill_flag",  err_illegal, 1'b1);
        end else if (op == 3'b000 || op == 3'b110) begin
            check("wb_busy", busy, 1'b1);
            check("wb_op",   alu_op_code, 3'b000);
            noise();
            step();
            if (op == 3'b110 && rd != 3'd0) m_regs[rd] = {6'b0, ins[9:0]};
            m_retire++;
        end else begin
            m_src1 = m_regs[rs1];
            m_src2 = (op == 3'b010 || op == 3'b100) ? {9'b0, ins[6:0]} : m_regs[rs2];
            res    = alu_model(op, m_src1, m_src2);
            check("iss_op",   alu_op_code, op);
            check("iss_src1", alu_src1, m_src1);
            check("iss_src2", alu_src2, m_src2);
            noise();
            step();
            for (int k = 0; k < TIMEOUT; k++) begin
                check("wait_busy", busy, 1'b1);
                check("wait_op",   alu_op_code, 3'b000);
                check("wait_src1", alu_src1, m_src1);
                check("wait_src2", alu_src2, m_src2);
                instr_valid = 1'($urandom);
                instr       = 16'($urandom);
                if (k == rst_k) begin
                    rst         = 1'b1;
                    instr_valid = 1'b0;
                    alu_done    = 1'b0;
                    step();
                    rst         = 1'b0;
                    alu_done    = 1'b1;
                    alu_result  = 16'hBEEF;
                    step();
                    alu_done    = 1'b0;
                    model_reset();
                    check("rst_src1", alu_src1, 16'h0);
                    check("rst_src2", alu_src2, 16'h0);
                    break;
                end
                if (k == delay) begin
                    alu_done   = 1'b1;
                    alu_result = res;
                    step();
                    check("wb_busy", busy, 1'b1);
                    check("wb_op",   alu_op_code, 3'b000);
                    noise();
                    step();
                    if (rd != 3'd0) m_regs[rd] = res;
                    m_retire++;
                    break;
                end
                alu_done   = 1'b0;
                alu_result = 16'($urandom);
                step();
                if (k == TIMEOUT - 1) m_tmo = 1'b1;
            end
        end
        instr_valid = 1'b0;
        alu_done    = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = 16'h0;
        alu_result  = 16'h0;
        alu_done    = 1'b0;
        dbg_addr    = 3'd0;
        model_reset();
        @(negedge clk);
        step();
        rst = 1'b0;
        check("rst_src1", alu_src1, 16'h0);
        check("rst_src2", alu_src2, 16'h0);

        // LDI r1,5 ; LDI r2,3 ; ADD r3,r1,r2 with alu_done one cycle after WAIT entry.
        run({3'b110, 3'd1, 10'd5}, 0, -1);
        run({3'b110, 3'd2, 10'd3}, 0, -1);
        run({3'b001, 3'd3, 3'd1, 3'd2, 4'd0}, 0, -1);
        dbg_addr = 3'd3;
        #1;
        check("add_r3", dbg_data, 16'd8);
        check("add_retire", retire_count, 16'd3);

        // ADDI with imm7 sign bit set: operand is zero-extended 0x0042.
        run({3'b010, 3'd4, 3'd1, 7'b1000010}, 1, -1);
        dbg_addr = 3'd4;
        #1;
        check("addi_r4", dbg_data, 16'h0047);

        // LDI to r0 is discarded but still retires.
        run({3'b110, 3'd0, 10'h3FF}, 0, -1);
        dbg_addr = 3'd0;
        #1;
        check("ldi_r0", dbg_data, 16'h0);
        check("ldi_r0_retire", retire_count, 16'd5);

        // Illegal opcode, then an ALU op that never completes.
        run({3'b111, 13'h0ABC}, 0, -1);
        check("ill_retire", retire_count, 16'd5);
        run({3'b001, 3'd5, 3'd1, 3'd2, 4'd0}, TIMEOUT, -1);
        check("tmo_flag", err_timeout, 1'b1);
        check("tmo_retire", retire_count, 16'd5);

        // Reset in the middle of WAIT, followed by a stray alu_done.
        run({3'b101, 3'd6, 3'd1, 3'd2, 4'd0}, TIMEOUT, 2);
        check("rst_ill", err_illegal, 1'b0);
        check("rst_tmo", err_timeout, 1'b0);
        check("rst_retire", retire_count, 16'd0);

        for (int n = 0; n < 150; n++) begin
            int d;
            d = ($urandom_range(0, 9) == 0) ? TIMEOUT : int'($urandom_range(0, 3));
            run(16'($urandom), d, -1);
        end
        check_idle("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
